// File: rtl/tub_encoder.sv
// Eight-digit seven-segment formatter: latches a 32-bit operand and renders it as hex,
// unsigned decimal or signed decimal segment bytes using a bit-serial double-dabble converter.
module tub_encoder (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] value_i,
  input  logic [1:0]  mode_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic [7:0]  tub1_o,
  output logic [7:0]  tub2_o,
  output logic [7:0]  tub3_o,
  output logic [7:0]  tub4_o,
  output logic [7:0]  tub5_o,
  output logic [7:0]  tub6_o,
  output logic [7:0]  tub7_o,
  output logic [7:0]  tub8_o
);

  typedef enum logic [1:0] {StIdle, StConv, StFmt} state_e;

  localparam logic [1:0] ModeHex   = 2'b00;
  localparam logic [1:0] ModeUdec  = 2'b01;
  localparam logic [1:0] ModeSdec  = 2'b10;
  localparam logic [1:0] ModeBlank = 2'b11;

  localparam logic [7:0] SegMinus = 8'h02;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0:    s = 8'hFC;
      4'h1:    s = 8'h60;
      4'h2:    s = 8'hDA;
      4'h3:    s = 8'hF2;
      4'h4:    s = 8'h66;
      4'h5:    s = 8'hB6;
      4'h6:    s = 8'hBE;
      4'h7:    s = 8'hE0;
      4'h8:    s = 8'hFE;
      4'h9:    s = 8'hF6;
      4'hA:    s = 8'hEE;
      4'hB:    s = 8'h3E;
      4'hC:    s = 8'h9C;
      4'hD:    s = 8'h7A;
      4'hE:    s = 8'h9E;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic        sign_q, sign_d;
  logic [31:0] shift_q, shift_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] tubs_q, tubs_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  logic [39:0] bcd_adj;
  logic [63:0] fmt_tubs;
  logic        fmt_ovf;
  logic        neg;
  int          msd;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 10; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  // Digit i drives the byte at tubs[8*i +: 8]; digit 0 is the rightmost tube.
  always_comb begin
    fmt_tubs = '0;
    fmt_ovf  = 1'b0;
    msd      = 0;
    neg      = (mode_q == ModeSdec) && sign_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    unique case (mode_q)
      ModeHex: begin
        for (int i = 0; i < 8; i++) fmt_tubs[8*i +: 8] = seg7(shift_q[4*i +: 4]);
      end
      ModeBlank: ;
      default: begin
        // A negative result needs one spare tube for the minus sign.
        if ((bcd_q[39:32] != 8'd0) || (neg && (bcd_q[31:28] != 4'd0))) begin
          fmt_tubs = {8{SegMinus}};
          fmt_ovf  = 1'b1;
        end else begin
          for (int i = 0; i < 8; i++) begin
            if (i <= msd)                fmt_tubs[8*i +: 8] = seg7(bcd_q[4*i +: 4]);
            else if (neg && i == msd + 1) fmt_tubs[8*i +: 8] = SegMinus;
          end
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    tubs_d  = tubs_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          mode_d  = mode_i;
          sign_d  = 1'b0;
          shift_d = value_i;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StFmt;
          if (mode_i == ModeUdec) begin
            state_d = StConv;
          end else if (mode_i == ModeSdec) begin
            state_d = StConv;
            sign_d  = value_i[31];
            shift_d = value_i[31] ? (~value_i + 32'd1) : value_i;
          end
        end
      end
      StConv: begin
        bcd_d   = {bcd_adj[38:0], shift_q[31]};
        shift_d = {shift_q[30:0], 1'b0};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFmt;
      end
      StFmt: begin
        tubs_d  = fmt_tubs;
        ovf_d   = fmt_ovf;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mode_q  <= ModeHex;
      sign_q  <= 1'b0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      tubs_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      tubs_q  <= tubs_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign tub1_o     = tubs_q[63:56];
  assign tub2_o     = tubs_q[55:48];
  assign tub3_o     = tubs_q[47:40];
  assign tub4_o     = tubs_q[39:32];
  assign tub5_o     = tubs_q[31:24];
  assign tub6_o     = tubs_q[23:16];
  assign tub7_o     = tubs_q[15:8];
  assign tub8_o     = tubs_q[7:0];

endmodule

// File: tb/tb_tub_encoder.sv
// Scoreboard bench for tub_encoder: driver pushes model results, monitor pops them on done.
module tb_tub_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] value = '0;
  logic [1:0]  mode = '0;
  logic        busy, done, overflow;
  logic [7:0]  tub1, tub2, tub3, tub4, tub5, tub6, tub7, tub8;

  tub_encoder dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (load),
    .value_i    (value),
    .mode_i     (mode),
    .busy_o     (busy),
    .done_o     (done),
    .overflow_o (overflow),
    .tub1_o     (tub1),
    .tub2_o     (tub2),
    .tub3_o     (tub3),
    .tub4_o     (tub4),
    .tub5_o     (tub5),
    .tub6_o     (tub6),
    .tub7_o     (tub7),
    .tub8_o     (tub8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] tubs;
    logic        ovf;
    longint      cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  longint      cyc = 0;
  logic [63:0] last_tubs = '0;
  logic        last_ovf = 1'b0;
  logic [7:0]  segtab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                               8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  wire [63:0] dut_tubs = {tub1, tub2, tub3, tub4, tub5, tub6, tub7, tub8};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand, rightmost digit first.
  function automatic exp_t model(input logic [31:0] v, input logic [1:0] m);
    exp_t            e;
    bit              neg;
    longint unsigned mag, lim, n;
    int              k;
    e.tubs = '0;
    e.ovf  = 1'b0;
    e.cyc  = 0;
    if (m == 2'b00) begin
      for (int i = 0; i < 8; i++) e.tubs[8*i +: 8] = segtab[v[4*i +: 4]];
    end else if (m != 2'b11) begin
      neg = (m == 2'b10) && v[31];
      mag = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
      lim = neg ? 64'd9_999_999 : 64'd99_999_999;
      if (mag > lim) begin
        e.tubs = {8{8'h02}};
        e.ovf  = 1'b1;
      end else begin
        n = mag;
        k = 0;
        do begin
          e.tubs[8*k +: 8] = segtab[int'(n % 10)];
          n = n / 10;
          k++;
        end while (n != 0);
        if (neg) e.tubs[8*k +: 8] = 8'h02;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_tubs = '0;
      last_ovf  = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 required no pending result (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("tubs_ovf", {overflow, dut_tubs}, {e.ovf, e.tubs});
        chk("done_cycle", 65'(cyc), 65'(e.cyc));
        chk("busy_at_done", 65'(busy), 65'(0));
        last_tubs = e.tubs;
        last_ovf  = e.ovf;
      end
    end else begin
      chk("hold", {overflow, dut_tubs}, {last_ovf, last_tubs});
    end
  end

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (busy) chk("idle_timeout", 65'(busy), 65'(0));
  endtask

  task automatic do_load(input logic [31:0] v, input logic [1:0] m);
    exp_t e;
    wait_idle();
    load  = 1'b1;
    value = v;
    mode  = m;
    @(posedge clk);
    #1;
    e     = model(v, m);
    e.cyc = cyc + ((m == 2'b01 || m == 2'b10) ? 33 : 1);
    sb.push_back(e);
    chk("busy_after_accept", 65'(busy), 65'(1));
    load  = 1'b0;
    value = $urandom;
    mode  = 2'($urandom);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return $urandom_range(0, 999);
      1:       return 32'd99_999_998 + $urandom_range(0, 3);
      2:       return 32'hFF67_6981 - $urandom_range(0, 2) + $urandom_range(0, 2);
      3:       return $urandom_range(0, 1) != 0 ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, overflow, dut_tubs}, 67'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {busy, done, overflow, dut_tubs}, 67'd0);

    do_load(32'h1234_ABCD, 2'b00);
    do_load(32'd12345, 2'b01);
    do_load(32'd0, 2'b01);
    do_load(32'hFFFF_FFD6, 2'b10);
    do_load(32'h8000_0000, 2'b10);
    do_load(32'd100_000_000, 2'b01);
    do_load(32'd99_999_999, 2'b01);
    do_load(32'hFF67_6981, 2'b10);
    do_load(32'hFF67_6980, 2'b10);
    do_load(32'hDEAD_BEEF, 2'b11);

    // Loads while busy (mid-conversion and at the FMT edge) must be dropped.
    do_load(32'd7_654_321, 2'b01);
    repeat (4) @(negedge clk);
    load = 1'b1; value = 32'hFFFF_FFFF; mode = 2'b00;
    @(negedge clk);
    load = 1'b0;
    repeat (27) @(negedge clk);
    load = 1'b1; value = 32'd42; mode = 2'b01;
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    #1;
    chk("fmt_edge_load_ignored", 65'(busy), 65'(0));

    // Asynchronous reset in the middle of a conversion.
    do_load(32'd31337, 2'b01);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_clears", {busy, done, overflow, dut_tubs}, 67'd0);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_load(32'd86_420, 2'b10);

    for (int i = 0; i < 60; i++) begin
      do_load(rand_val(), 2'($urandom_range(0, 3)));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 65'(sb.size()), 65'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tub_encoder.md
# tub_encoder

Upstream formatter for the eight-digit seven-segment scan driver. Latches a 32-bit value on a load strobe, converts it to hexadecimal, unsigned decimal or signed decimal, and holds eight segment bytes `tub1`..`tub8` that the scan driver multiplexes onto the display. Decimal conversion is a sequential shift-add-3 (double dabble) engine, one bit per cycle, with a busy/done handshake. `tub1` is the leftmost digit and `tub8` the rightmost.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `load`  in  1  start strobe, sampled only in IDLE.
- `value`  in  32  operand, latched when `load` is accepted.
- `mode`  in  2  latched with `value`:
  - 00 = hex
  - 01 = unsigned decimal
  - 10 = signed decimal
  - 11 = blank
- `busy`  out  1  high from acceptance until format completes.
- `done`  out  1  one-cycle pulse when the `tub*` outputs update.
- `overflow`  out  1  set if the last decimal result did not fit; held until the next format.
- `tub1`..`tub8`  out  8 each  segment bytes, active-high, bit7..0 = a,b,c,d,e,f,g,dp.

## Operation
- Segment codes:
  - Digits 0-F: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E.
  - Other symbols: minus=02, blank=00. dp is always 0.
- States: IDLE, CONV, FMT.
  - IDLE: `load`=1 latches `value` and `mode`.
    - Mode 00 or 11 → FMT.
    - Mode 01 → CONV with magnitude = `value`.
    - Mode 10 → CONV with magnitude = two's-complement absolute value (32-bit unsigned; 0x80000000 → 2147483648) and the sign bit latched.
  - CONV: 40-bit BCD register (10 digits) plus 32-bit shift register.
    - Each cycle: add 3 to every BCD nibble that is ≥5, then shift left one bit, taking the magnitude MSB into the BCD LSB.
    - A 5-bit counter runs 0..31; on count 31 → FMT.
  - FMT: one cycle. Writes all eight `tub*` outputs, pulses `done`, updates `overflow`, → IDLE.
- Hex format:
  - `tub1` = value[31:28] … `tub8` = value[3:0].
  - No leading-zero suppression. `overflow`=0.
- Unsigned decimal:
  - If BCD digits 9..8 ≠ 0 (value > 99,999,999), every tub = 02 and `overflow`=1.
  - Otherwise the 8 low digits are shown with leading zeros blanked. Value 0 shows FC on `tub8` only.
- Signed decimal:
  - Non-negative values follow the unsigned rules.
  - A negative value whose magnitude exceeds 9,999,999 gives overflow (all 02).
  - Otherwise leading zeros are blanked and the minus (02) sits in the position immediately left of the most significant digit.
- Blank mode: all tubs 00, `overflow`=0.
- `load` while `busy` is ignored and not queued. `value`/`mode` changes after acceptance have no effect.

## Timing
- Reset (async assert, any state) → IDLE:
  - `tub1`..`tub8`=00, `busy`=0, `done`=0, `overflow`=0.
  - BCD/shift/counter registers cleared.
  - Reset mid-conversion aborts with no `done`.
- `load` accepted at edge N → `busy`=1 after edge N.
- Decimal modes:
  - CONV occupies edges N+1..N+32.
  - FMT at edge N+33: `tub*` update, `done`=1 and `busy`=0 after N+33.
  - `done` returns to 0 after N+34.
- Hex and blank modes: FMT at edge N+1, so the `done` pulse and updated outputs appear after N+1.
- `load` high at the same edge that FMT completes is not accepted. The earliest re-accept is the following edge.
- `tub*` outputs change only at the FMT edge or on reset, and hold stable between.

## Test plan
- Reset, then hex 0x1234ABCD, load at N → after N+1: tub1..8 = 60 DA F2 66 EE 3E 9C 7A, `done` one cycle, `overflow`=0.
- Unsigned decimal 12345 → after N+33: tub1..3=00, tub4..8 = 60 DA F2 66 B6. Then value 0 → tub8=FC, others 00.
- Signed decimal 0xFFFFFFD6 (-42) → tub1..5=00, tub6=02, tub7=66, tub8=DA. Signed 0x80000000 → all 02, `overflow`=1.
- Unsigned 100,000,000 → all 02, `overflow`=1. Unsigned 99,999,999 → all F6, `overflow`=0.
- Load pulses at N+5 and at the FMT edge while busy → ignored: exactly one `done`, and outputs reflect the first operand.
- Assert `rst_n`=0 during CONV cycle 10 → all outputs 0 immediately, no `done`. A new load after release converts correctly.
